// File: rtl/ren_tile_splitter.sv
// Tile subdivider: pops a parent tile and emits a row-major grid of
// sub-tiles (or the parent whole) to the binner over valid/ready.
module ren_tile_splitter #(
  parameter int COORD_W    = 16,
  parameter int SIZE_W     = 8,
  parameter int SPLIT_LOG2 = 1,
  parameter int MIN_SIZE   = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_en,
  input  logic               i_mode,
  input  logic               i_empty,
  output logic               o_fifo_read,
  input  logic [COORD_W-1:0] i_tile_x,
  input  logic [COORD_W-1:0] i_tile_y,
  input  logic [SIZE_W-1:0]  i_tile_size,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [COORD_W-1:0] o_tile_x,
  output logic [COORD_W-1:0] o_tile_y,
  output logic [SIZE_W-1:0]  o_tile_size,
  output logic               o_last,
  output logic               o_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;

  localparam logic [SPLIT_LOG2-1:0] CMAX = '1;

  logic [1:0]            state;
  logic [SPLIT_LOG2-1:0] sx;
  logic [SPLIT_LOG2-1:0] sy;
  logic [COORD_W-1:0]    base_x;
  logic [COORD_W-1:0]    acc_x;
  logic [COORD_W-1:0]    acc_y;
  logic [COORD_W-1:0]    step;
  logic [SIZE_W-1:0]     osize;
  logic [SIZE_W-1:0]     sub;
  logic                  pt;
  logic                  pt_n;
  logic                  xfer;
  logic                  at_end;

  assign sub    = i_tile_size >> SPLIT_LOG2;
  assign pt_n   = i_mode
                | (int'(sub) < MIN_SIZE)
                | (sub == '0);

  assign o_valid = (state == EMIT);
  assign o_busy  = (state != IDLE);
  assign xfer    = o_valid & i_ready;
  assign at_end  = pt | ((sx == CMAX) & (sy == CMAX));
  assign o_last  = o_valid & at_end;

  // Gated by rstn so a reset never leaks a pop strobe.
  assign o_fifo_read = rstn & (state == IDLE)
                     & i_en & ~i_empty;

  assign o_tile_x    = acc_x;
  assign o_tile_y    = acc_y;
  assign o_tile_size = osize;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      sx     <= '0;
      sy     <= '0;
      base_x <= '0;
      acc_x  <= '0;
      acc_y  <= '0;
      step   <= '0;
      osize  <= '0;
      pt     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (o_fifo_read) state <= FETCH;
        end
        FETCH: begin
          base_x <= i_tile_x;
          acc_x  <= i_tile_x;
          acc_y  <= i_tile_y;
          step   <= COORD_W'(sub);
          osize  <= pt_n ? i_tile_size : sub;
          pt     <= pt_n;
          sx     <= '0;
          sy     <= '0;
          state  <= EMIT;
        end
        EMIT: begin
          if (xfer) begin
            if (at_end) begin
              state <= IDLE;
            end else if (sx == CMAX) begin
              sx    <= '0;
              sy    <= sy + 1'b1;
              acc_x <= base_x;
              acc_y <= acc_y + step;
            end else begin
              sx    <= sx + 1'b1;
              acc_x <= acc_x + step;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ren_tile_splitter.sv
// Directed bench for ren_tile_splitter: 2x2 and 4x4 instances fed
// from a shared tile FIFO model, table vectors plus corner sequences.
module tb_ren_tile_splitter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        i_en = 1'b1;
  logic        i_mode = 1'b0;
  logic        i_ready = 1'b1;
  logic        sel = 1'b0;
  logic [15:0] i_tile_x = '0;
  logic [15:0] i_tile_y = '0;
  logic [7:0]  i_tile_size = '0;

  logic        rd1, v1, l1, b1;
  logic [15:0] x1, y1;
  logic [7:0]  s1;
  logic        rd2, v2, l2, b2;
  logic [15:0] x2, y2;
  logic [7:0]  s2;

  logic [39:0] mem [0:63];
  int          wp = 0;
  int          rp = 0;
  logic        empty;
  assign empty = (wp == rp);

  always @(posedge clk) begin
    if ((rd1 | rd2) && (rp != wp)) begin
      {i_tile_x, i_tile_y, i_tile_size} <= mem[rp[5:0]];
      rp <= rp + 1;
    end
  end

  ren_tile_splitter #(
    .COORD_W(16), .SIZE_W(8), .SPLIT_LOG2(1), .MIN_SIZE(4)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .i_en(i_en), .i_mode(i_mode),
    .i_empty(empty | sel), .o_fifo_read(rd1),
    .i_tile_x(i_tile_x), .i_tile_y(i_tile_y),
    .i_tile_size(i_tile_size), .o_valid(v1), .i_ready(i_ready),
    .o_tile_x(x1), .o_tile_y(y1), .o_tile_size(s1),
    .o_last(l1), .o_busy(b1)
  );

  ren_tile_splitter #(
    .COORD_W(16), .SIZE_W(8), .SPLIT_LOG2(2), .MIN_SIZE(4)
  ) u_dut2 (
    .clk(clk), .rstn(rstn), .i_en(i_en), .i_mode(i_mode),
    .i_empty(empty | ~sel), .o_fifo_read(rd2),
    .i_tile_x(i_tile_x), .i_tile_y(i_tile_y),
    .i_tile_size(i_tile_size), .o_valid(v2), .i_ready(i_ready),
    .o_tile_x(x2), .o_tile_y(y2), .o_tile_size(s2),
    .o_last(l2), .o_busy(b2)
  );

  logic        ov, ol, ob, ord;
  logic [15:0] ox, oy;
  logic [7:0]  os;
  assign ov  = sel ? v2 : v1;
  assign ol  = sel ? l2 : l1;
  assign ob  = sel ? b2 : b1;
  assign ord = sel ? rd2 : rd1;
  assign ox  = sel ? x2 : x1;
  assign oy  = sel ? y2 : y1;
  assign os  = sel ? s2 : s1;

  typedef struct {
    logic [15:0]        x;
    logic [15:0]        y;
    logic [7:0]         sz;
    logic               md;
    int                 rmode;
    int                 n;
    logic [7:0]         esz;
    logic [0:15][15:0]  ex;
    logic [0:15][15:0]  ey;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] x, y,
                              input logic [7:0] sz,
                              input logic md, input int rmode,
                              input int n, input logic [7:0] esz,
                              input logic [63:0] ex4, ey4);
    vec_t v;
    v.x = x; v.y = y; v.sz = sz; v.md = md;
    v.rmode = rmode; v.n = n; v.esz = esz;
    v.ex = '0; v.ey = '0;
    v.ex[0:3] = ex4;
    v.ey[0:3] = ey4;
    return v;
  endfunction

  task automatic push(input logic [15:0] x, y, input logic [7:0] sz);
    mem[wp[5:0]] = {x, y, sz};
    wp++;
  endtask

  // Called on a negedge with the DUT idle.
  task automatic run(input vec_t v, input bit nopush, input bit mid);
    int k = 0;
    int t = 0;
    int first = -1;
    bit hv = 0;
    logic [15:0] hx, hy;
    if (!nopush) push(v.x, v.y, v.sz);
    i_mode = v.md;
    i_ready = 1'b1;
    #1 chk("pop", ord, 1);
    while (k < v.n && t < 80) begin
      @(negedge clk);
      t++;
      i_ready = (v.rmode == 0) ? 1'b1 : ((t % 3) == 0);
      if (hv) begin
        chk("hold_x", ox, hx);
        chk("hold_y", oy, hy);
        hv = 0;
      end
      if (ov && first < 0) begin
        first = t;
        chk("latency", t, 2);
      end
      if (ov && i_ready) begin
        chk("x", ox, v.ex[k]);
        chk("y", oy, v.ey[k]);
        chk("size", os, v.esz);
        chk("last", ol, (k == v.n - 1));
        k++;
        if (mid && k == 1) begin
          i_en = 1'b0;
          i_mode = ~i_mode;
          push(v.x, v.y, v.sz);
        end
      end else if (ov) begin
        hx = ox;
        hy = oy;
        hv = 1;
      end
    end
    chk("count", k, v.n);
    @(negedge clk);
    i_ready = 1'b1;
    chk("busy_end", ob, 0);
    chk("valid_end", ov, 0);
  endtask

  vec_t tab [0:8];
  vec_t v5;

  initial begin
    tab[0] = mk(16, 32, 8, 0, 0, 4, 4,
                {16'd16, 16'd20, 16'd16, 16'd20},
                {16'd32, 16'd32, 16'd36, 16'd36});
    tab[1] = mk(0, 0, 8, 1, 0, 1, 8, '0, '0);
    tab[2] = mk(0, 0, 4, 0, 0, 1, 4, '0, '0);
    tab[3] = mk(16, 32, 8, 0, 1, 4, 4,
                {16'd16, 16'd20, 16'd16, 16'd20},
                {16'd32, 16'd32, 16'd36, 16'd36});
    tab[4] = mk(100, 200, 16, 0, 0, 4, 8,
                {16'd100, 16'd108, 16'd100, 16'd108},
                {16'd200, 16'd200, 16'd208, 16'd208});
    tab[5] = mk(65532, 65532, 16, 0, 0, 4, 8,
                {16'd65532, 16'd4, 16'd65532, 16'd4},
                {16'd65532, 16'd65532, 16'd4, 16'd4});
    tab[6] = mk(0, 0, 0, 0, 0, 1, 0, '0, '0);
    tab[7] = mk(8, 8, 11, 0, 1, 4, 5,
                {16'd8, 16'd13, 16'd8, 16'd13},
                {16'd8, 16'd8, 16'd13, 16'd13});
    tab[8] = mk(3, 5, 8, 1, 0, 1, 8,
                {16'd3, 16'd0, 16'd0, 16'd0},
                {16'd5, 16'd0, 16'd0, 16'd0});

    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", ov, 0);
    chk("rst_busy", ob, 0);
    chk("rst_read", ord, 0);
    chk("rst_x", ox, 0);
    chk("rst_size", os, 0);
    chk("rst_last", ol, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("empty_busy", ob, 0);
    chk("empty_read", ord, 0);

    for (int i = 0; i < 9; i++) run(tab[i], 0, 0);

    // Drop i_en and flip i_mode mid-parent.
    run(tab[0], 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en_low_read", ord, 0);
      chk("en_low_busy", ob, 0);
    end
    i_en = 1'b1;
    run(tab[0], 1, 0);

    // 4x4 instance with x wrap.
    sel = 1'b1;
    v5 = mk(65528, 0, 16, 0, 0, 16, 4, '0, '0);
    for (int k = 0; k < 16; k++) begin
      v5.ex[k] = 16'(65528 + 4 * (k % 4));
      v5.ey[k] = 16'(4 * (k / 4));
    end
    run(v5, 0, 0);
    sel = 1'b0;
    @(negedge clk);

    // Reset in the middle of the second sub-tile.
    push(16, 32, 8);
    i_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_second_x", ox, 20);
    push(16, 32, 8);
    #2 rstn = 1'b0;
    #1;
    chk("t6_valid", ov, 0);
    chk("t6_busy", ob, 0);
    chk("t6_read", ord, 0);
    chk("t6_x", ox, 0);
    @(negedge clk);
    chk("t6_read_hold", ord, 0);
    rstn = 1'b1;
    run(tab[0], 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_idle", ob, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
